// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command queue: selector codes, legality check
// and issue FSM state encoding.
package alu_pkg;

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_AND = 3'b001;
    localparam logic [2:0] SEL_OR  = 3'b010;
    localparam logic [2:0] SEL_MUL = 3'b011;
    localparam logic [2:0] SEL_SUB = 3'b100;
    localparam logic [2:0] SEL_TER = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Codes above SEL_TER (110/111) have no ALU operation behind them.
    function automatic logic sel_legal(input logic [2:0] sel);
        return sel <= SEL_TER;
    endfunction

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Command, ALU and result handshake signals of the ALU command queue.
interface alu_cmd_queue_if #(
    parameter int unsigned W = 32
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_sel;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_r;
    logic         alu_zf;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_r;
    logic         res_zf;
    logic [2:0]   res_sel;
    logic         res_err;

    // Producer/consumer and ALU side.
    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, res_ready, alu_r, alu_zf,
        input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_r, res_zf, res_sel, res_err
    );

    // Queue side.
    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, res_ready, alu_r, alu_zf,
        output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_r, res_zf, res_sel, res_err
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on rdata whenever not empty.
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 67
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          wdata,
    output logic [DW-1:0]          rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Issue stage for the combinational ALU: buffers commands, issues one at a time,
// captures the result and returns it in order over a valid/ready handshake.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input logic            clk,
    input logic            rst,
    alu_cmd_queue_if.slave bus
);
    localparam int unsigned DW = 3 + 2 * W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t        state;
    logic [DW-1:0] head;
    logic [2:0]    head_sel;
    logic [W-1:0]  head_a;
    logic [W-1:0]  head_b;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop_c;
    logic          legal_c;

    assign {head_sel, head_a, head_b} = head;
    assign bus.cmd_ready = !fifo_full;
    assign legal_c       = sel_legal(bus.alu_sel);

    // Pop from IDLE, or in WAIT on the same edge the result is handed off.
    assign pop_c = !fifo_empty && ((state == IDLE) || ((state == WAIT) && bus.res_ready));

    alu_cmd_fifo #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (bus.cmd_valid),
        .pop  (pop_c),
        .wdata({bus.cmd_sel, bus.cmd_a, bus.cmd_b}),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_sel   <= '0;
            bus.res_valid <= 1'b0;
            bus.res_r     <= '0;
            bus.res_zf    <= 1'b0;
            bus.res_sel   <= '0;
            bus.res_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        bus.alu_a   <= head_a;
                        bus.alu_b   <= head_b;
                        bus.alu_sel <= head_sel;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal selectors still flow through but report zeros with err set.
                    bus.res_r     <= legal_c ? bus.alu_r : '0;
                    bus.res_zf    <= legal_c && bus.alu_zf;
                    bus.res_sel   <= bus.alu_sel;
                    bus.res_err   <= !legal_c;
                    bus.res_valid <= 1'b1;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        if (pop_c) begin
                            bus.alu_a   <= head_a;
                            bus.alu_b   <= head_b;
                            bus.alu_sel <= head_sel;
                            state       <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_full_count: assert property (@(posedge clk) disable iff (rst)
        fifo_full == (fifo_count == CW'(DEPTH)));

endmodule
